// File: rtl/dmem_pkg.sv
// Shared definitions for the pipelined-core data memory: state encoding,
// init-content selectors and the read-latency legality check.
package dmem_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int INIT_ZERO  = 0;
    localparam int INIT_IDENT = 1;

    function automatic bit read_lat_ok(input int lat);
        return (lat == 1) || (lat == 2);
    endfunction

endpackage

// File: rtl/dmem_read_pipe.sv
// Read response chain: LAT stages of valid/data registers.
// Data stages only load on a valid beat, so the output holds between responses.
module dmem_read_pipe #(
    parameter int DATA_W = 8,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    genvar gi;
    generate
        for (gi = 0; gi < LAT; gi++) begin : g_stage
            logic              valid_reg;
            logic [DATA_W-1:0] data_reg;
            logic              stage_valid;
            logic [DATA_W-1:0] stage_data;

            if (gi == 0) begin : g_first
                assign stage_valid = in_valid;
                assign stage_data  = in_data;
            end else begin : g_next
                assign stage_valid = g_stage[gi-1].valid_reg;
                assign stage_data  = g_stage[gi-1].data_reg;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg <= 1'b0;
                    data_reg  <= '0;
                end else begin
                    valid_reg <= stage_valid;
                    if (stage_valid) begin
                        data_reg <= stage_data;
                    end
                end
            end
        end
    endgenerate

    assign out_valid = g_stage[LAT-1].valid_reg;
    assign out_data  = g_stage[LAT-1].data_reg;

endmodule

// File: rtl/data_memory_pipe.sv
// Parametrised data memory between EX/MEM and MEM/WB: init sweep after reset,
// valid/ready requests, 1- or 2-cycle reads, out-of-range flagging, debug tap.
module data_memory_pipe
    import dmem_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int READ_LAT  = 1,
    parameter int INIT_MODE = 1,
    parameter int DBG_ADDR  = 10
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              addr_err,
    output logic              init_done,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_C  = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [IDX_W-1:0] DBG_IDX = IDX_W'(DBG_ADDR);

    generate
        if (!read_lat_ok(READ_LAT)) begin : g_bad_lat
            $error("data_memory_pipe: READ_LAT must be 1 or 2");
        end
        if (DEPTH < 2 || DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
            $error("data_memory_pipe: DEPTH out of range for ADDR_W");
        end
        if (DBG_ADDR < 0 || DBG_ADDR >= DEPTH) begin : g_bad_dbg
            $error("data_memory_pipe: DBG_ADDR must be below DEPTH");
        end
    endgenerate

    state_t            state_reg;
    logic [ADDR_W:0]   cnt_reg;
    logic              ready_reg;
    logic              done_reg;
    logic              err_reg;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              in_range;
    logic [IDX_W-1:0]  req_idx;
    logic [IDX_W-1:0]  init_idx;
    logic [DATA_W-1:0] init_val;
    logic [DATA_W-1:0] rd_data;

    assign accept   = req_valid && ready_reg;
    assign in_range = ({1'b0, req_addr} < DEPTH_C);
    assign req_idx  = IDX_W'(req_addr);
    assign init_idx = IDX_W'(cnt_reg);
    assign init_val = (INIT_MODE == INIT_IDENT) ? DATA_W'(cnt_reg) : '0;

    // cnt_reg is one bit wider than the address so DEPTH = 2**ADDR_W still reaches LAST_C cleanly.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= ST_INIT;
            cnt_reg   <= '0;
            ready_reg <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_INIT: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_C) begin
                        state_reg <= ST_RUN;
                        ready_reg <= 1'b1;
                        done_reg  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    ready_reg <= 1'b1;
                    done_reg  <= 1'b1;
                end
                default: begin
                    state_reg <= ST_INIT;
                    cnt_reg   <= '0;
                    ready_reg <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= accept && !in_range;
        end
    end

    // The array has no reset; the sweep is what gives it defined contents.
    always_ff @(posedge CLK) begin
        if (state_reg == ST_INIT) begin
            mem[init_idx] <= init_val;
        end else if (accept && req_write && in_range) begin
            mem[req_idx] <= req_wdata;
        end
    end

    assign rd_data = in_range ? mem[req_idx] : '0;

    dmem_read_pipe #(
        .DATA_W (DATA_W),
        .LAT    (READ_LAT)
    ) u_read_pipe (
        .clk       (CLK),
        .rst_n     (RST_N),
        .in_valid  (accept && !req_write),
        .in_data   (rd_data),
        .out_valid (rsp_valid),
        .out_data  (rsp_data)
    );

    assign req_ready = ready_reg;
    assign init_done = done_reg;
    assign addr_err  = err_reg;
    assign dbg_data  = mem[DBG_IDX];

endmodule

// File: tb/tb_data_memory_pipe.sv
// Bench for data_memory_pipe: four parameterisations share clock and reset;
// read responses and addr_err pulses are predicted into queues and checked on output.
module tb_data_memory_pipe;

    localparam int N = 4;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    int          cyc = 0;

    logic        rv [N];
    logic        rw [N];
    logic [7:0]  ra [N];
    logic [15:0] wd [N];
    logic        ready [N];
    logic        rspv [N];
    logic        aerr [N];
    logic        idone [N];
    logic [15:0] rspd [N];
    logic [15:0] dbg [N];
    logic [7:0]  rspd8 [3];
    logic [7:0]  dbg8 [3];
    logic [15:0] rspd16;
    logic [15:0] dbg16;

    exp_t        exp_q [N][$];
    int          err_q [N][$];
    logic [15:0] model [N][256];

    int          n_checks = 0;
    int          n_errors = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic int depth_of(input int k);
        return (k == 2) ? 200 : (k == 3) ? 16 : 256;
    endfunction

    function automatic int lat_of(input int k);
        return (k == 1) ? 2 : 1;
    endfunction

    function automatic logic [15:0] mask_of(input int k);
        return (k == 3) ? 16'hFFFF : 16'h00FF;
    endfunction

    function automatic logic [15:0] init_of(input int k, input int i);
        return (k == 3) ? 16'h0000 : (16'(i) & mask_of(k));
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut8
            data_memory_pipe #(
                .DATA_W    (8),
                .ADDR_W    (8),
                .DEPTH     ((gi == 2) ? 200 : 256),
                .READ_LAT  ((gi == 1) ? 2 : 1),
                .INIT_MODE (1),
                .DBG_ADDR  (10)
            ) dut (
                .CLK       (CLK),
                .RST_N     (RST_N),
                .req_valid (rv[gi]),
                .req_ready (ready[gi]),
                .req_write (rw[gi]),
                .req_addr  (ra[gi]),
                .req_wdata (wd[gi][7:0]),
                .rsp_valid (rspv[gi]),
                .rsp_data  (rspd8[gi]),
                .addr_err  (aerr[gi]),
                .init_done (idone[gi]),
                .dbg_data  (dbg8[gi])
            );
            assign rspd[gi] = {8'h00, rspd8[gi]};
            assign dbg[gi]  = {8'h00, dbg8[gi]};
        end
    endgenerate

    data_memory_pipe #(
        .DATA_W    (16),
        .ADDR_W    (4),
        .DEPTH     (16),
        .READ_LAT  (1),
        .INIT_MODE (0),
        .DBG_ADDR  (10)
    ) dut16 (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .req_valid (rv[3]),
        .req_ready (ready[3]),
        .req_write (rw[3]),
        .req_addr  (ra[3][3:0]),
        .req_wdata (wd[3]),
        .rsp_valid (rspv[3]),
        .rsp_data  (rspd16),
        .addr_err  (aerr[3]),
        .init_done (idone[3]),
        .dbg_data  (dbg16)
    );
    assign rspd[3] = rspd16;
    assign dbg[3]  = dbg16;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, expv, cyc);
        end
    endtask

    // Response and addr_err monitors, sampled on the falling edge.
    generate
        for (gi = 0; gi < N; gi++) begin : g_mon
            exp_t e;
            bit   err_exp;
            always @(negedge CLK) begin
                if (RST_N) begin
                    while (exp_q[gi].size() > 0 && exp_q[gi][0].cyc < cyc) begin
                        check_val($sformatf("rsp_missing[%0d]", gi), 32'(cyc), 32'(exp_q[gi][0].cyc));
                        void'(exp_q[gi].pop_front());
                    end
                    if (rspv[gi]) begin
                        if (exp_q[gi].size() == 0) begin
                            check_val($sformatf("rsp_spurious[%0d]", gi), 32'd1, 32'd0);
                        end else begin
                            e = exp_q[gi].pop_front();
                            check_val($sformatf("rsp_cycle[%0d]", gi), 32'(cyc), 32'(e.cyc));
                            check_val($sformatf("rsp_data[%0d]", gi), 32'(rspd[gi]), 32'(e.data));
                            $display("rsp k=%0d data=0x%0h cycle=%0d", gi, rspd[gi], cyc);
                        end
                    end
                    while (err_q[gi].size() > 0 && err_q[gi][0] < cyc) void'(err_q[gi].pop_front());
                    err_exp = (err_q[gi].size() > 0 && err_q[gi][0] == cyc);
                    if (err_exp) void'(err_q[gi].pop_front());
                    check_val($sformatf("addr_err[%0d]", gi), 32'(aerr[gi]), 32'(err_exp));
                end
            end
        end
    endgenerate

    // Called on a falling edge; holds the request across one rising edge.
    task automatic req(input int k, input bit w, input logic [7:0] addr, input logic [15:0] data);
        logic [15:0] d;
        exp_t        e;
        d = '0;
        rv[k] = 1'b1;
        rw[k] = w;
        ra[k] = addr;
        wd[k] = data;
        if (int'(addr) < depth_of(k)) begin
            if (w) model[k][addr] = data & mask_of(k);
            else   d = model[k][addr];
        end else begin
            err_q[k].push_back(cyc + 1);
        end
        if (!w) begin
            e.data = d;
            e.cyc  = cyc + lat_of(k);
            exp_q[k].push_back(e);
        end
        $display("req k=%0d %s addr=%0d wdata=0x%0h", k, w ? "wr" : "rd", addr, data);
        @(negedge CLK);
        rv[k] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Releases reset on a falling edge and measures how long each instance stays not-ready.
    task automatic release_reset();
        int  low_cnt [N];
        bit  all_ready;
        for (int k = 0; k < N; k++) begin
            low_cnt[k] = 0;
            for (int i = 0; i < 256; i++) model[k][i] = init_of(k, i);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        for (int t = 0; t < 600; t++) begin
            #1;
            all_ready = 1'b1;
            for (int k = 0; k < N; k++) begin
                if (!ready[k]) begin
                    low_cnt[k]++;
                    all_ready = 1'b0;
                end
            end
            if (all_ready) break;
            @(negedge CLK);
        end
        for (int k = 0; k < N; k++) begin
            check_val($sformatf("init_len[%0d]", k), 32'(low_cnt[k]), 32'(depth_of(k)));
            check_val($sformatf("init_done[%0d]", k), 32'(idone[k]), 32'd1);
            check_val($sformatf("dbg_init[%0d]", k), 32'(dbg[k]), 32'(init_of(k, 10)));
        end
        @(negedge CLK);
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            rv[k] = 1'b0;
            rw[k] = 1'b0;
            ra[k] = '0;
            wd[k] = '0;
        end
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        for (int k = 0; k < N; k++) begin
            check_val($sformatf("rst_ready[%0d]", k), 32'(ready[k]), 32'd0);
            check_val($sformatf("rst_rsp_valid[%0d]", k), 32'(rspv[k]), 32'd0);
            check_val($sformatf("rst_rsp_data[%0d]", k), 32'(rspd[k]), 32'd0);
            check_val($sformatf("rst_addr_err[%0d]", k), 32'(aerr[k]), 32'd0);
            check_val($sformatf("rst_init_done[%0d]", k), 32'(idone[k]), 32'd0);
        end

        release_reset();

        req(0, 1'b0, 8'd37, 16'h0);
        idle(2);
        req(1, 1'b0, 8'd3, 16'h0);
        req(1, 1'b0, 8'd4, 16'h0);
        req(1, 1'b0, 8'd5, 16'h0);
        idle(3);

        req(0, 1'b1, 8'd10, 16'h00A5);
        check_val("dbg_after_write", 32'(dbg[0]), 32'h00A5);
        req(0, 1'b0, 8'd10, 16'h0);
        idle(2);

        req(2, 1'b1, 8'd220, 16'h0055);
        req(2, 1'b0, 8'd220, 16'h0);
        req(2, 1'b0, 8'd199, 16'h0);
        idle(2);

        req(3, 1'b0, 8'd7, 16'h0);
        req(3, 1'b1, 8'd7, 16'hBEEF);
        req(3, 1'b0, 8'd7, 16'h0);
        idle(2);

        for (int i = 0; i < 60; i++) begin
            int          k;
            logic [7:0]  a;
            k = int'($urandom_range(0, 3));
            a = 8'($urandom_range(0, 255));
            if (k == 3) a = a & 8'h0F;
            req(k, 1'($urandom_range(0, 1)), a, 16'($urandom));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(4);

        // Reset with a read in flight: the response must vanish at once.
        req(0, 1'b1, 8'd10, 16'h00FF);
        check_val("dbg_before_reset", 32'(dbg[0]), 32'h00FF);
        rv[0] = 1'b1;
        rw[0] = 1'b0;
        ra[0] = 8'd5;
        @(posedge CLK);
        #2;
        RST_N = 1'b0;
        rv[0] = 1'b0;
        #1;
        check_val("midrst_rsp_valid", 32'(rspv[0]), 32'd0);
        check_val("midrst_rsp_data", 32'(rspd[0]), 32'd0);
        for (int k = 0; k < N; k++) begin
            exp_q[k].delete();
            err_q[k].delete();
        end
        idle(2);

        release_reset();
        req(0, 1'b0, 8'd10, 16'h0);
        idle(4);

        for (int k = 0; k < N; k++) begin
            check_val($sformatf("drain_rsp[%0d]", k), 32'(exp_q[k].size()), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/data_memory_pipe.md
Name: data_memory_pipe

Overview:
- Parametrised data memory for the pipelined core; successor to the fixed 8-bit, 256-entry, single-latency data memory.
- Adds:
  - configurable data width, address width and depth;
  - selectable read latency (1 or 2);
  - valid/ready request handshake;
  - a hardware initialisation sweep after reset;
  - out-of-range detection;
  - a parametrised debug tap.
- Sits between the EX/MEM stage register and the MEM/WB stage register.

Parameters:
- DATA_W, 8: data word width in bits.
- ADDR_W, 8: address width in bits.
- DEPTH, 256: number of words; legal range 2 to 2**ADDR_W.
- READ_LAT, 1: read latency in cycles; legal values are 1 or 2.
- INIT_MODE, 1: contents after the init sweep. 0 = all zero; 1 = Memory[i] = i truncated to DATA_W.
- DBG_ADDR, 10: word index exposed on dbg_data; must be less than DEPTH.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- req_valid  in  1  request present this cycle.
- req_ready  out  1  block accepts a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  read data valid this cycle.
- rsp_data  out  DATA_W  read data.
- addr_err  out  1  one-cycle pulse: accepted request had req_addr >= DEPTH.
- init_done  out  1  init sweep complete.
- dbg_data  out  DATA_W  combinational view of Memory[DBG_ADDR].

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (CLK, RST_N).
  - While RST_N = 0: req_ready = 0, rsp_valid = 0, rsp_data = 0, addr_err = 0, init_done = 0.
  - While RST_N = 0: state = INIT, init counter = 0, all read-pipe valid bits cleared.
  - The array itself is not reset; it is rewritten by the sweep.
- States:
  - INIT: writes Memory[cnt] = (INIT_MODE ? cnt : 0) and increments cnt once per cycle.
  - INIT exits to RUN after writing index DEPTH-1, so INIT lasts exactly DEPTH cycles after RST_N rises.
  - RUN: terminal until reset. init_done = 1 and req_ready = 1 in RUN only.
- Accept: a request is accepted when req_valid && req_ready. At most one request per cycle. There is no response backpressure.
- Write: the array updates at the accepting edge. No response is produced (rsp_valid stays 0 for it).
- Read:
  - READ_LAT = 1: rsp_data is registered at the accepting edge; rsp_valid = 1 in the next cycle.
  - READ_LAT = 2: one additional output register stage; rsp_valid rises 2 cycles after acceptance.
  - Back-to-back reads pipeline at one per cycle. Responses return in request order.
- Read-after-write:
  - A read accepted in the cycle after a write to the same address returns the new data.
  - A read is never in the same cycle as a write (one request per cycle), so no same-cycle conflict exists.
- rsp_data holds its last value while rsp_valid = 0. It is not cleared except by reset.
- Out of range (req_addr >= DEPTH, possible only when DEPTH < 2**ADDR_W):
  - The request is still accepted. Writes are dropped.
  - Reads return rsp_data = 0 with normal rsp_valid timing.
  - addr_err pulses in the cycle after acceptance, for both reads and writes.
- req_valid = 0: no array change, no response, addr_err = 0.
- Requests presented during INIT are ignored (req_ready = 0). The requester must hold them.
- Reset mid-operation:
  - In-flight reads are discarded; rsp_valid drops immediately (asynchronously).
  - The sweep restarts from index 0. Writes made before the reset are overwritten by the sweep.
- dbg_data reflects the sweep value during INIT and any write to DBG_ADDR from the cycle after that write.
- Widths:
  - Init value is cnt zero-extended or truncated to DATA_W.
  - The init counter is ADDR_W+1 bits wide so that DEPTH = 2**ADDR_W terminates correctly.

Decomposition:
- Shared package dmem_pkg: state encoding (ST_INIT, ST_RUN), INIT_MODE constants (INIT_ZERO, INIT_IDENT), READ_LAT legality check.
- One sub-module, dmem_read_pipe: the parametrised READ_LAT valid/data register chain with async clear.
- The array, FSM and accept logic stay in data_memory_pipe.

Test Plan:
- Default parameters:
  - Release RST_N → req_ready = 0 for exactly 256 cycles, then init_done = 1 and dbg_data = 8'd10.
  - Read addr 8'd37 → rsp_valid one cycle later with rsp_data = 8'd37.
- Write addr 8'd10 data 8'hA5, then read addr 8'd10 in the next cycle → dbg_data = 8'hA5 one cycle after the write; rsp_data = 8'hA5 one cycle after the read.
- READ_LAT = 2, reads 3, 4, 5 on consecutive cycles → rsp_valid high for 3 consecutive cycles starting 2 cycles after the first read, with data 3, 4, 5 in order.
- DEPTH = 200, ADDR_W = 8:
  - Write 8'd220 data 8'h55 → addr_err pulses 1 cycle.
  - Then read 8'd220 → rsp_data = 0 and addr_err pulses again.
  - Then read 8'd199 → rsp_data = 8'd199, addr_err = 0.
- INIT_MODE = 0, DATA_W = 16, ADDR_W = 4, DEPTH = 16:
  - Read 4'd7 after init → rsp_data = 16'h0000.
  - Write 4'd7 16'hBEEF then read 4'd7 → 16'hBEEF.
- Write 8'd10 data 8'hFF, then assert RST_N = 0 mid-stream while a read is in flight:
  - rsp_valid = 0 immediately.
  - After release: 256 cycles of INIT, then dbg_data = 8'd10 again.
